// File: rtl/gpio_scan_sequencer_if.sv
// Control/status bundle between the GPIO scan sequencer (slave) and whatever
// launches and pauses it (master, e.g. PLL-lock logic or a bench).
interface gpio_scan_sequencer_if #(
    parameter int NUM_BANKS = 27
);
    logic                     start;
    logic                     hold;
    logic [8*NUM_BANKS-1:0]   gpio_out;
    logic [4:0]               bank_idx;
    logic                     busy;
    logic                     done;

    modport master (
        output start,
        output hold,
        input  gpio_out,
        input  bank_idx,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  hold,
        output gpio_out,
        output bank_idx,
        output busy,
        output done
    );
endinterface

// File: rtl/gpio_scan_sequencer.sv
// Walking-one then common up-count pattern generator for the GPIO output banks.
// Optional macro GPIO_SCAN_LOOP_EN: DONE restarts the walk instead of idling.
module gpio_scan_sequencer #(
    parameter int NUM_BANKS = 27,
    parameter int DWELL     = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    gpio_scan_sequencer_if.slave   bus
);
    localparam int         GW         = 8 * NUM_BANKS;
    localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
    localparam logic [4:0]  BANK_LAST  = 5'(NUM_BANKS - 1);

    if (NUM_BANKS < 1 || NUM_BANKS > 32) begin : g_bad_num_banks
        $error("gpio_scan_sequencer: NUM_BANKS must be in 1..32");
    end
    if (DWELL < 2 || DWELL > 65535) begin : g_bad_dwell
        $error("gpio_scan_sequencer: DWELL must be in 2..65535");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WALK,
        S_COUNT,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     dwell_q, dwell_d;
    logic [2:0]      bit_q,   bit_d;
    logic [4:0]      bank_q,  bank_d;
    logic [7:0]      pat_q,   pat_d;
    logic [GW-1:0]   gpio_q,  gpio_d;
    logic            busy_q,  busy_d;
    logic            done_q,  done_d;
    logic            wrap;

    assign wrap = (dwell_q == DWELL_LAST);

    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves it
        // unassigned; otherwise synthesis would infer a latch.
        state_d = state_q;
        dwell_d = dwell_q;
        bit_d   = bit_q;
        bank_d  = bank_q;
        pat_d   = pat_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.hold) begin
                    state_d = S_WALK;
                    dwell_d = '0;
                    bit_d   = '0;
                    bank_d  = '0;
                    pat_d   = '0;
                end
            end
            S_WALK: begin
                if (!bus.hold) begin
                    if (wrap) begin
                        dwell_d = '0;
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            if (bank_q == BANK_LAST) begin
                                state_d = S_COUNT;
                                bank_d  = '0;
                                pat_d   = '0;
                            end else begin
                                bank_d  = bank_q + 5'd1;
                            end
                        end
                    end else begin
                        dwell_d = dwell_q + 16'd1;
                    end
                end
            end
            S_COUNT: begin
                if (!bus.hold) begin
                    if (wrap) begin
                        dwell_d = '0;
                        pat_d   = pat_q + 8'd1;
                        if (pat_q == 8'hFF) state_d = S_DONE;
                    end else begin
                        dwell_d = dwell_q + 16'd1;
                    end
                end
            end
            S_DONE: begin
                // hold is deliberately ignored here so done never stretches.
`ifdef GPIO_SCAN_LOOP_EN
                state_d = S_WALK;
`else
                state_d = S_IDLE;
`endif
                dwell_d = '0;
                bit_d   = '0;
                bank_d  = '0;
                pat_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are derived from the next state so they change on the same
        // edge as the dwell wrap and stay frozen while hold holds the state.
        gpio_d = '0;
        busy_d = (state_d == S_WALK) || (state_d == S_COUNT);
        done_d = (state_d == S_DONE);
        if (state_d == S_WALK) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (bank_d == 5'(b)) gpio_d[8*b +: 8] = 8'h01 << bit_d;
            end
        end else if (state_d == S_COUNT) begin
            gpio_d = {NUM_BANKS{pat_d}};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            dwell_q <= '0;
            bit_q   <= '0;
            bank_q  <= '0;
            pat_q   <= '0;
            gpio_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            bit_q   <= bit_d;
            bank_q  <= bank_d;
            pat_q   <= pat_d;
            gpio_q  <= gpio_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.gpio_out = gpio_q;
    assign bus.bank_idx = bank_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule
